proc_run_controller: RTL and testbench
======================================

Name: proc_run_controller

Overview:
- Run/reset sequencer that drives the MIPS processor's reset and clock-enable from a single start pulse.
- Holds the core in reset for a fixed number of cycles, then enables it for a programmable number of cycles or until halted. It then freezes the core with state intact for inspection.
- Sits between the top level or bench control and the processor's reset and enable inputs.
- Replaces hand-toggled reset/clock sequences with a counted, repeatable run.

Parameters:
- RST_HOLD, 2, cycles core_reset stays high after start is accepted; legal range >= 1.
- CYC_W, 16, width of the cycle limit and counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high controller reset.
- start  input  1  request to begin a run; sampled on rising edge.
- halt_req  input  1  request to stop a run early; sampled on rising edge.
- cycle_limit  input  CYC_W  number of enabled core cycles per run; 0 = unlimited; latched when start is accepted.
- core_reset  output  1  reset to the processor, active-high, registered.
- core_en  output  1  processor clock-enable, registered.
- cycle_count  output  CYC_W  enabled cycles completed in the current or last run.
- running  output  1  high while in RUN.
- done  output  1  high while in HALTED.
- aborted  output  1  high in HALTED when the run ended by halt_req and not by limit.

Behaviour:
- States: IDLE, RST_WAIT, RUN, HALTED. All outputs are registered.
- reset high (asynchronous, any time, including mid-run): state=IDLE, core_reset=1, core_en=0, cycle_count=0, running=0, done=0, aborted=0, hold counter=0, latched limit=0. These take effect immediately, without waiting for a clock edge.
- IDLE: core_reset=1, core_en=0.
  - start=1 at edge E0 -> RST_WAIT, hold counter=RST_HOLD-1, limit latched, cycle_count=0.
  - halt_req ignored.
- RST_WAIT: core_reset=1, core_en=0.
  - On each edge, hold counter==0 -> RUN with core_reset=0, core_en=1, running=1. Otherwise decrement.
  - core_reset therefore falls after edge E0+RST_HOLD.
  - start and halt_req ignored.
- RUN: core_reset=0, core_en=1.
  - Each edge: cycle_count <= cycle_count+1, saturating at 2^CYC_W-1.
  - Limit reached: latched limit != 0 and cycle_count+1 == limit -> HALTED with core_en=0, running=0, done=1, aborted=0. core_en is therefore high for exactly limit cycles.
  - halt_req=1 (limit not reached this edge) -> HALTED with aborted=1. The count still includes this edge's increment.
  - halt_req and limit reached on the same edge -> HALTED with aborted=0.
  - start ignored.
  - Unlimited (limit 0): the core runs until halt_req. cycle_count holds at all-ones once saturated; the core keeps running.
- HALTED: core_reset=0 (core state preserved), core_en=0; cycle_count, done and aborted hold.
  - start=1 -> RST_WAIT exactly as from IDLE: clears done, aborted and cycle_count, and relatches the limit.
  - halt_req ignored.
- start held high continuously starts only one run per IDLE/HALTED visit; it is not edge-detected.
- cycle_limit changes after a run is accepted have no effect until the next start.
- Never assert core_reset and core_en together.

Test Plan:
- Reset state: reset=1, then released with start=0 for 5 cycles -> core_reset=1, core_en=0, running=0, done=0, cycle_count=0 throughout.
- Basic run: RST_HOLD=2, cycle_limit=18, start pulse at E0.
  - core_reset high through E0+2 and low after it.
  - core_en high for exactly 18 cycles.
  - Then done=1, aborted=0, cycle_count=18, core_reset stays 0.
- Early halt: cycle_limit=18, halt_req pulsed on the 5th RUN edge -> HALTED next, cycle_count=5, aborted=1, core_en=0.
- Simultaneous halt and limit: cycle_limit=4, halt_req asserted on the 4th RUN edge -> done=1, aborted=0, cycle_count=4.
- Restart and latch: from HALTED, start with cycle_limit=3; change cycle_limit to 10 during RST_WAIT -> RST_WAIT replays, core_en high for 3 cycles, count ends at 3.
- Mid-run async reset: assert reset between edges during RUN at cycle_count=7 -> core_en=0 and core_reset=1 immediately (before next edge), state IDLE, cycle_count=0. Unlimited run (limit 0, CYC_W=4) saturates count at 15 and stays running until halt_req.

Source files
------------

// File: rtl/proc_run_controller.sv
// Run/reset sequencer for the MIPS core: one start pulse yields a counted reset
// hold, a bounded (or halt-terminated) enabled run, then a frozen inspection state.
module proc_run_controller #(
  parameter int unsigned RST_HOLD = 2,
  parameter int unsigned CYC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [CYC_W-1:0] cycle_limit,
  output logic             core_reset,
  output logic             core_en,
  output logic [CYC_W-1:0] cycle_count,
  output logic             running,
  output logic             done,
  output logic             aborted
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RST_WAIT, RUN, HALTED} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold;
  logic [CYC_W-1:0]  limit;
  logic [CYC_W-1:0]  count_next;
  logic              limit_hit;

  always_comb begin
    count_next = (cycle_count == '1) ? cycle_count : cycle_count + CYC_W'(1);
    // Compare against the unsaturated increment; the limit is always reached
    // before saturation, so wrap-around can never produce a false match.
    limit_hit  = (limit != '0) && ((cycle_count + CYC_W'(1)) == limit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      limit       <= '0;
      cycle_count <= '0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RST_WAIT;
            hold        <= HOLD_W'(RST_HOLD - 1);
            limit       <= cycle_limit;
            cycle_count <= '0;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
          end
        end
        RST_WAIT: begin
          if (hold == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            core_en    <= 1'b1;
            running    <= 1'b1;
          end else begin
            hold <= hold - HOLD_W'(1);
          end
        end
        RUN: begin
          cycle_count <= count_next;
          if (limit_hit || halt_req) begin
            state   <= HALTED;
            core_en <= 1'b0;
            running <= 1'b0;
            done    <= 1'b1;
            aborted <= !limit_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
// Directed bench for proc_run_controller: a default instance (RST_HOLD=2, CYC_W=16)
// and a narrow instance (RST_HOLD=1, CYC_W=4) for hold and saturation boundaries.
module tb_proc_run_controller;

  logic        clk;
  logic        reset;
  logic        start, halt_req;
  logic [15:0] cycle_limit;
  logic        core_reset, core_en, running, done, aborted;
  logic [15:0] cycle_count;

  logic        s_start, s_halt;
  logic [3:0]  s_limit;
  logic        s_core_reset, s_core_en, s_running, s_done, s_aborted;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  proc_run_controller #(.RST_HOLD(2), .CYC_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .cycle_limit(cycle_limit), .core_reset(core_reset), .core_en(core_en),
    .cycle_count(cycle_count), .running(running), .done(done), .aborted(aborted)
  );

  proc_run_controller #(.RST_HOLD(1), .CYC_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .halt_req(s_halt),
    .cycle_limit(s_limit), .core_reset(s_core_reset), .core_en(s_core_en),
    .cycle_count(s_count), .running(s_running), .done(s_done), .aborted(s_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on the default instance and advances to the first RUN sample.
  task automatic start_run(input logic [15:0] lim);
    start = 1'b1;
    cycle_limit = lim;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (core_reset !== 1'b1 || core_en !== 1'b0 || running !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || cycle_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_async: rst=%b en=%b run=%b done=%b ab=%b cnt=%0d, want 1 0 0 0 0 0",
               core_reset, core_en, running, done, aborted, cycle_count);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      halt_req = (i == 2);
      tick();
      n_checks++;
      if (core_reset !== 1'b1 || core_en !== 1'b0 || running !== 1'b0 || done !== 1'b0 ||
          cycle_count !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: rst=%b en=%b run=%b done=%b cnt=%0d, want 1 0 0 0 0",
                 i, core_reset, core_en, running, done, cycle_count);
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic test_basic_run();
    int n;
    start = 1'b1;
    cycle_limit = 16'd18;
    tick();
    start = 1'b0;
    n_checks++;
    if (core_reset !== 1'b1 || core_en !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_e0: rst=%b en=%b run=%b, want 1 0 0", core_reset, core_en, running);
    end
    tick();
    n_checks++;
    if (core_reset !== 1'b1 || core_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_e1: rst=%b en=%b, want 1 0", core_reset, core_en);
    end
    tick();
    n_checks++;
    if (core_reset !== 1'b0 || core_en !== 1'b1 || running !== 1'b1 || cycle_count !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_e2: rst=%b en=%b run=%b cnt=%0d, want 0 1 1 0",
               core_reset, core_en, running, cycle_count);
    end
    n = 0;
    while (core_en === 1'b1 && n < 100) begin
      n_checks++;
      if (core_reset !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_overlap: core_reset=%b with core_en=1, want 0", core_reset);
      end
      n++;
      tick();
    end
    n_checks++;
    if (n != 18) begin
      n_fail++;
      $display("FAIL basic_en_cycles: got %0d, want 18", n);
    end
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || cycle_count !== 16'd18 || core_reset !== 1'b0 ||
        running !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_halted: done=%b ab=%b cnt=%0d rst=%b run=%b, want 1 0 18 0 0",
               done, aborted, cycle_count, core_reset, running);
    end
  endtask

  task automatic test_early_halt();
    start_run(16'd18);
    repeat (4) tick();
    n_checks++;
    if (cycle_count !== 16'd4 || core_en !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_pre: cnt=%0d en=%b, want 4 1", cycle_count, core_en);
    end
    halt_req = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || cycle_count !== 16'd5 || core_en !== 1'b0 ||
        running !== 1'b0 || core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_state: done=%b ab=%b cnt=%0d en=%b run=%b rst=%b, want 1 1 5 0 0 0",
               done, aborted, cycle_count, core_en, running, core_reset);
    end
    tick();
    tick();
    halt_req = 1'b0;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || cycle_count !== 16'd5 || core_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_hold: done=%b ab=%b cnt=%0d en=%b, want 1 1 5 0",
               done, aborted, cycle_count, core_en);
    end
  endtask

  task automatic test_halt_and_limit();
    start_run(16'd4);
    repeat (3) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || cycle_count !== 16'd4 || core_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_limit: done=%b ab=%b cnt=%0d en=%b, want 1 0 4 0",
               done, aborted, cycle_count, core_en);
    end
  endtask

  task automatic test_restart_latch();
    int n;
    start = 1'b1;
    cycle_limit = 16'd3;
    tick();
    start = 1'b0;
    cycle_limit = 16'd10;
    n_checks++;
    if (core_reset !== 1'b1 || core_en !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
        cycle_count !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_e0: rst=%b en=%b done=%b ab=%b cnt=%0d, want 1 0 0 0 0",
               core_reset, core_en, done, aborted, cycle_count);
    end
    tick();
    tick();
    n = 0;
    while (core_en === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 3 || cycle_count !== 16'd3 || done !== 1'b1 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_latch: en_cycles=%0d cnt=%0d done=%b ab=%b, want 3 3 1 0",
               n, cycle_count, done, aborted);
    end
  endtask

  task automatic test_async_reset();
    start_run(16'd0);
    repeat (7) tick();
    n_checks++;
    if (cycle_count !== 16'd7 || core_en !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: cnt=%0d en=%b, want 7 1", cycle_count, core_en);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (core_en !== 1'b0 || core_reset !== 1'b1 || cycle_count !== 16'd0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: en=%b rst=%b cnt=%0d run=%b, want 0 1 0 0",
               core_en, core_reset, cycle_count, running);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (core_reset !== 1'b1 || core_en !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0) begin
      n_fail++;
      $display("FAIL arst_idle: rst=%b en=%b done=%b cnt=%0d, want 1 0 0 0",
               core_reset, core_en, done, cycle_count);
    end
  endtask

  task automatic test_saturation();
    s_start = 1'b1;
    s_limit = 4'd0;
    tick();
    s_start = 1'b0;
    n_checks++;
    if (s_core_reset !== 1'b1 || s_core_en !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_e0: rst=%b en=%b, want 1 0", s_core_reset, s_core_en);
    end
    tick();
    n_checks++;
    if (s_core_reset !== 1'b0 || s_core_en !== 1'b1 || s_running !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold1: rst=%b en=%b run=%b, want 0 1 1", s_core_reset, s_core_en, s_running);
    end
    repeat (14) tick();
    n_checks++;
    if (s_count !== 4'd14) begin
      n_fail++;
      $display("FAIL sat_14: cnt=%0d, want 14", s_count);
    end
    repeat (6) tick();
    n_checks++;
    if (s_count !== 4'd15 || s_running !== 1'b1 || s_core_en !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%0d run=%b en=%b, want 15 1 1", s_count, s_running, s_core_en);
    end
    s_halt = 1'b1;
    tick();
    s_halt = 1'b0;
    n_checks++;
    if (s_done !== 1'b1 || s_aborted !== 1'b1 || s_count !== 4'd15 || s_core_en !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_halt: done=%b ab=%b cnt=%0d en=%b, want 1 1 15 0",
               s_done, s_aborted, s_count, s_core_en);
    end
  endtask

  task automatic test_max_limit();
    int n;
    s_start = 1'b1;
    s_limit = 4'd15;
    tick();
    s_start = 1'b0;
    tick();
    n = 0;
    while (s_core_en === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 15 || s_count !== 4'd15 || s_done !== 1'b1 || s_aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL max_limit: en_cycles=%0d cnt=%0d done=%b ab=%b, want 15 15 1 0",
               n, s_count, s_done, s_aborted);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    cycle_limit = '0;
    s_start = 1'b0;
    s_halt = 1'b0;
    s_limit = '0;
    test_reset();
    test_basic_run();
    test_early_halt();
    test_halt_and_limit();
    test_restart_latch();
    test_async_reset();
    test_saturation();
    test_max_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
